// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter
//   Shares the register-file write port between the pipeline WB stage
//   (highest priority) and a FIFO-buffered auxiliary (mult/div) result
//   stream. A starving aux head forces a single pipeline bubble.
//
//   Optional statistics counters: define WB_ARB_STATS_EN to add the
//   ConflictCount and ForceCount outputs.
//
//   FSM states:
//     state | meaning
//     IDLE  | FIFO empty, nothing waiting
//     PEND  | FIFO head waiting for a free write slot, wait timer running
//     FORCE | StallPipe high for this one cycle, head owns the write port
module wb_port_arbiter #(
  parameter int AUX_DEPTH = 2,
  parameter int MAX_WAIT  = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        PipeRegWrite,
  input  logic [4:0]  PipeWriteReg,
  input  logic [31:0] PipeWriteData,
  input  logic        AuxValid,
  output logic        AuxReady,
  input  logic [4:0]  AuxWriteReg,
  input  logic [31:0] AuxWriteData,
  output logic        RegWrite,
  output logic [4:0]  WriteRegister,
  output logic [31:0] WriteData,
  output logic        StallPipe
`ifdef WB_ARB_STATS_EN
  ,
  output logic [15:0] ConflictCount,
  output logic [15:0] ForceCount
`endif
);

  localparam int PtrW  = (AUX_DEPTH > 1) ? $clog2(AUX_DEPTH) : 1;
  localparam int CntW  = $clog2(AUX_DEPTH + 1);
  localparam int WaitW = $clog2(MAX_WAIT + 1);
  localparam logic [CntW-1:0]  DepthC   = CntW'(AUX_DEPTH);
  localparam logic [WaitW-1:0] MaxWaitC = WaitW'(MAX_WAIT);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PEND  = 2'd1,
    FORCE = 2'd2
  } stateT;

  stateT state;

  // Aux FIFO storage; the valid bit lets a superseded entry drain silently.
  logic [4:0]           fifoReg  [AUX_DEPTH];
  logic [31:0]          fifoData [AUX_DEPTH];
  logic [AUX_DEPTH-1:0] fifoValid;
  logic [PtrW-1:0]      wrPtr;
  logic [PtrW-1:0]      rdPtr;
  logic [CntW-1:0]      count;
  logic [CntW-1:0]      countNext;

  // Down-counter: cycles the head may still be passed over before a bubble.
  logic [WaitW-1:0]     waitLeft;

  logic        fifoEmpty;
  logic        fifoFull;
  logic        push;
  logic        pop;
  logic        grantPipe;
  logic        grantAux;
  logic        pipeKill;
  logic [4:0]  headReg;
  logic [31:0] headData;
  logic        headValid;

  assign fifoEmpty = (count == '0);
  assign fifoFull  = (count == DepthC);
  // Conservative: no credit is given for a pop happening in the same cycle.
  assign AuxReady  = !fifoFull;
  assign push      = AuxValid && !fifoFull && !Reset;

  assign headReg   = fifoReg[rdPtr];
  assign headData  = fifoData[rdPtr];
  assign headValid = fifoValid[rdPtr];

  // Write-port grant: forced bubble, then pipe, then buffered aux head.
  always_comb begin
    grantPipe = 1'b0;
    grantAux  = 1'b0;
    if (!Reset) begin
      if (StallPipe) begin
        grantAux = !fifoEmpty;
      end else if (PipeRegWrite) begin
        grantPipe = 1'b1;
      end else begin
        grantAux = !fifoEmpty;
      end
    end
  end

  assign pop       = grantAux;
  assign countNext = count + CntW'(push) - CntW'(pop);
  // A real pipe write (not $0, not held by a bubble) makes older aux results stale.
  assign pipeKill  = grantPipe && (PipeWriteReg != 5'd0);

  // Register-file write port; $0 and superseded heads consume the slot without writing.
  always_comb begin
    RegWrite      = 1'b0;
    WriteRegister = PipeWriteReg;
    WriteData     = PipeWriteData;
    if (grantPipe) begin
      RegWrite = (PipeWriteReg != 5'd0);
    end else if (grantAux) begin
      WriteRegister = headReg;
      WriteData     = headData;
      RegWrite      = headValid && (headReg != 5'd0);
    end
  end

  // FIFO payload storage, written on accepted pushes only.
  always_ff @(posedge Clk) begin
    if (push) begin
      fifoReg[wrPtr]  <= AuxWriteReg;
      fifoData[wrPtr] <= AuxWriteData;
    end
  end

  // FIFO pointers, occupancy and per-entry valid bits (supersede then push, push wins).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      count     <= '0;
      fifoValid <= '0;
    end else begin
      for (int i = 0; i < AUX_DEPTH; i++) begin
        if (pipeKill && (fifoReg[i] == PipeWriteReg)) begin
          fifoValid[i] <= 1'b0;
        end
      end
      if (push) begin
        fifoValid[wrPtr] <= 1'b1;
        wrPtr            <= wrPtr + PtrW'(1);
      end
      if (pop) begin
        rdPtr <= rdPtr + PtrW'(1);
      end
      count <= countNext;
    end
  end

  // Starvation FSM with registered StallPipe (high only while in FORCE).
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= IDLE;
      waitLeft  <= MaxWaitC;
      StallPipe <= 1'b0;
    end else begin
      StallPipe <= 1'b0;
      case (state)
        IDLE: begin
          waitLeft <= MaxWaitC;
          if (push) begin
            state <= PEND;
          end
        end
        PEND: begin
          if (pop) begin
            waitLeft <= MaxWaitC;
            if (countNext == '0) begin
              state <= IDLE;
            end
          end else if ((waitLeft == WaitW'(1)) && PipeRegWrite) begin
            state     <= FORCE;
            StallPipe <= 1'b1;
          end else if (waitLeft > WaitW'(1)) begin
            waitLeft <= waitLeft - WaitW'(1);
          end
        end
        FORCE: begin
          waitLeft <= MaxWaitC;
          state    <= (countNext != '0) ? PEND : IDLE;
        end
        default: begin
          state    <= IDLE;
          waitLeft <= MaxWaitC;
        end
      endcase
    end
  end

`ifdef WB_ARB_STATS_EN
  // Saturating event counters: pipe/aux contention cycles and forced bubbles.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ConflictCount <= '0;
      ForceCount    <= '0;
    end else begin
      if (PipeRegWrite && !fifoEmpty && (ConflictCount != 16'hFFFF)) begin
        ConflictCount <= ConflictCount + 16'd1;
      end
      if (StallPipe && (ForceCount != 16'hFFFF)) begin
        ForceCount <= ForceCount + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb_wb_port_arbiter
//   Directed sequence for wb_port_arbiter (AUX_DEPTH=2, MAX_WAIT=4).
//   Each step queues its expected write-port / handshake outcome, then the
//   sample point pops it and compares against the DUT.
module tb_wb_port_arbiter;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        PipeRegWrite;
  logic [4:0]  PipeWriteReg;
  logic [31:0] PipeWriteData;
  logic        AuxValid;
  logic        AuxReady;
  logic [4:0]  AuxWriteReg;
  logic [31:0] AuxWriteData;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic        StallPipe;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       name;
    logic        we;
    logic [4:0]  r;
    logic [31:0] d;
    logic        stall;
    logic        ready;
  } expT;

  expT expQ[$];

  wb_port_arbiter #(.AUX_DEPTH(2), .MAX_WAIT(4)) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .PipeRegWrite (PipeRegWrite),
    .PipeWriteReg (PipeWriteReg),
    .PipeWriteData(PipeWriteData),
    .AuxValid     (AuxValid),
    .AuxReady     (AuxReady),
    .AuxWriteReg  (AuxWriteReg),
    .AuxWriteData (AuxWriteData),
    .RegWrite     (RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .StallPipe    (StallPipe)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string step, input string tag,
                     input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed %h expected %h", step, tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, queue expectation, compare at negedge.
  task automatic cyc(input string name,
                     input logic prw, input logic [4:0] pr, input logic [31:0] pd,
                     input logic av, input logic [4:0] ar, input logic [31:0] ad,
                     input logic ewe, input logic [4:0] er, input logic [31:0] ed,
                     input logic est, input logic erdy);
    expT e;
    PipeRegWrite  = prw;
    PipeWriteReg  = pr;
    PipeWriteData = pd;
    AuxValid      = av;
    AuxWriteReg   = ar;
    AuxWriteData  = ad;
    expQ.push_back('{name, ewe, er, ed, est, erdy});
    @(negedge Clk);
    e = expQ.pop_front();
    chk(e.name, "RegWrite", {31'd0, RegWrite}, {31'd0, e.we});
    if (e.we) begin
      chk(e.name, "WriteRegister", {27'd0, WriteRegister}, {27'd0, e.r});
      chk(e.name, "WriteData", WriteData, e.d);
    end
    chk(e.name, "StallPipe", {31'd0, StallPipe}, {31'd0, e.stall});
    chk(e.name, "AuxReady", {31'd0, AuxReady}, {31'd0, e.ready});
    @(posedge Clk);
    #1;
  endtask

  task automatic idleInputs();
    PipeRegWrite  = 1'b0;
    PipeWriteReg  = 5'd0;
    PipeWriteData = 32'd0;
    AuxValid      = 1'b0;
    AuxWriteReg   = 5'd0;
    AuxWriteData  = 32'd0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset = 1'b1;
    idleInputs();
    repeat (2) @(posedge Clk);
    #1;
    Reset = 1'b0;

    // reset state
    cyc("rst",   0, 0, 0,            0, 0, 0,             0, 0, 0,             0, 1);

    // pipe only
    cyc("pipe",  1, 8, 32'h1234,     0, 0, 0,             1, 8, 32'h1234,      0, 1);

    // aux into idle slot, visible next cycle
    cyc("aux0",  0, 0, 0,            1, 9, 32'hAAAA,      0, 0, 0,             0, 1);
    cyc("aux1",  0, 0, 0,            0, 0, 0,             1, 9, 32'hAAAA,      0, 1);
    cyc("aux2",  0, 0, 0,            0, 0, 0,             0, 0, 0,             0, 1);

    // starvation: 4 waiting cycles then one forced bubble
    cyc("stv1",  1, 10, 32'h100,     1, 11, 32'h111,      1, 10, 32'h100,      0, 1);
    cyc("stv2",  1, 10, 32'h101,     0, 0, 0,             1, 10, 32'h101,      0, 1);
    cyc("stv3",  1, 10, 32'h102,     0, 0, 0,             1, 10, 32'h102,      0, 1);
    cyc("stv4",  1, 10, 32'h103,     0, 0, 0,             1, 10, 32'h103,      0, 1);
    cyc("stv5",  1, 10, 32'h104,     0, 0, 0,             1, 10, 32'h104,      0, 1);
    cyc("stv6",  1, 10, 32'h105,     0, 0, 0,             1, 11, 32'h111,      1, 1);
    cyc("stv7",  1, 10, 32'h105,     0, 0, 0,             1, 10, 32'h105,      0, 1);

    // full FIFO under continuous pipe writes
    cyc("full1", 1, 12, 32'h200,     1, 13, 32'h300,      1, 12, 32'h200,      0, 1);
    cyc("full2", 1, 12, 32'h201,     1, 14, 32'h301,      1, 12, 32'h201,      0, 1);
    cyc("full3", 1, 12, 32'h202,     0, 0, 0,             1, 12, 32'h202,      0, 0);
    cyc("full4", 1, 12, 32'h203,     0, 0, 0,             1, 12, 32'h203,      0, 0);
    cyc("full5", 1, 12, 32'h204,     0, 0, 0,             1, 12, 32'h204,      0, 0);
    cyc("full6", 1, 12, 32'h205,     0, 0, 0,             1, 13, 32'h300,      1, 0);
    cyc("full7", 1, 12, 32'h205,     0, 0, 0,             1, 12, 32'h205,      0, 1);
    cyc("full8", 0, 0, 0,            0, 0, 0,             1, 14, 32'h301,      0, 1);
    cyc("full9", 0, 0, 0,            0, 0, 0,             0, 0, 0,             0, 1);

    // supersede: buffered reg 5 overwritten by the pipe, drains silently
    cyc("sup1",  0, 0, 0,            1, 5, 32'h1,         0, 0, 0,             0, 1);
    cyc("sup2",  1, 5, 32'h2,        0, 0, 0,             1, 5, 32'h2,         0, 1);
    cyc("sup3",  0, 0, 0,            0, 0, 0,             0, 0, 0,             0, 1);
    cyc("sup4",  0, 0, 0,            0, 0, 0,             0, 0, 0,             0, 1);

    // same-cycle collision: younger aux result survives
    cyc("col1",  1, 6, 32'h60,       1, 6, 32'h61,        1, 6, 32'h60,        0, 1);
    cyc("col2",  0, 0, 0,            0, 0, 0,             1, 6, 32'h61,        0, 1);

    // register $0 from both sources
    cyc("zer1",  0, 0, 0,            1, 0, 32'h777,       0, 0, 0,             0, 1);
    cyc("zer2",  0, 0, 0,            0, 0, 0,             0, 0, 0,             0, 1);
    cyc("zer3",  1, 0, 32'h5,        0, 0, 0,             0, 0, 0,             0, 1);

    // reset with two entries buffered
    cyc("rfl1",  1, 15, 32'h400,     1, 16, 32'h500,      1, 15, 32'h400,      0, 1);
    cyc("rfl2",  1, 15, 32'h401,     1, 17, 32'h501,      1, 15, 32'h401,      0, 1);
    cyc("rfl3",  1, 15, 32'h402,     0, 0, 0,             1, 15, 32'h402,      0, 0);
    idleInputs();
    Reset = 1'b1;
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    cyc("rfl4",  0, 0, 0,            0, 0, 0,             0, 0, 0,             0, 1);
    cyc("rfl5",  0, 0, 0,            0, 0, 0,             0, 0, 0,             0, 1);
    cyc("rfl6",  0, 0, 0,            0, 0, 0,             0, 0, 0,             0, 1);
    cyc("rfl7",  1, 3, 32'h33,       0, 0, 0,             1, 3, 32'h33,        0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
